// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit slice per cycle through a
// ripple of full adders, then holds the result under a valid/ready handshake.
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic             ripple_c;
  logic             chunk_cout;
  logic             c_into_msb;

  always_comb begin
    a_chunk    = '0;
    b_chunk    = '0;
    chunk_sum  = '0;
    ripple_c   = carry_q;
    c_into_msb = carry_q;
    sum_d      = sum_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    // c_into_msb is only meaningful on the last chunk, where it feeds ovf
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_into_msb = ripple_c;
      chunk_sum[i] = a_chunk[i] ^ b_chunk[i] ^ ripple_c;
      ripple_c     = (a_chunk[i] & b_chunk[i]) | (ripple_c & (a_chunk[i] ^ b_chunk[i]));
    end
    chunk_cout = ripple_c;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IW'(k)) sum_d[k*CHUNK +: CHUNK] = chunk_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtract is folded into the operands: a + ~b + ~cin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= chunk_cout;
          if (idx_q == IW'(N - 1)) begin
            cout_q  <= chunk_cout;
            ovf_q   <= c_into_msb ^ chunk_cout;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Random and directed checks of serial_chunk_adder against an arithmetic
// reference model (whole-word add/subtract, latency counted in cycles).
module tb_serial_chunk_adder;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  serial_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy for N edges after a transfer, then holds the result.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] p_sum = '0, e_sum = '0;
  logic         p_cout = 1'b0, e_cout = 1'b0;
  logic         p_ovf = 1'b0, e_ovf = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] bp;
    logic         c0;
    logic [W:0]   full;
    int           sres;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
    end else if (!m_busy && !m_done) begin
      if (in_valid) begin
        bp     = sub ? ~b : b;
        c0     = sub ? ~cin : cin;
        full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
        sres   = int'($signed(a)) + int'($signed(bp)) + int'(c0);
        p_sum  = full[W-1:0];
        p_cout = full[W];
        p_ovf  = (sres > 127) || (sres < -128);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == N) begin
        m_busy = 1'b0; m_done = 1'b1;
        e_sum = p_sum; e_cout = p_cout; e_ovf = p_ovf;
      end
    end else if (out_ready) begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", in_ready, !m_busy && !m_done);
      chk("out_valid", out_valid, m_done);
      if (!m_busy) begin
        chk("sum", sum, e_sum);
        chk("cout", cout, e_cout);
        chk("ovf", ovf, e_ovf);
      end
    end
  end

  // One operation; lit=1 also checks hand-computed literal results.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                    input logic ts, input int hold, input bit lit,
                    input logic [W-1:0] xs, input logic xc, input logic xo);
    int guard;
    int lat;
    logic [W-1:0] s0;
    logic c_s, o_s;
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 50);
    chk("latency", lat, N);
    if (lit) begin
      chk("lit_sum", sum, xs);
      chk("lit_cout", cout, xc);
      chk("lit_ovf", ovf, xo);
    end
    s0 = sum; c_s = cout; o_s = ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_sum", sum, s0);
      chk("hold_flags", {cout, ovf}, {c_s, o_s});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_idle", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 2'b00);
    checking = 1'b1;

    op(8'h3C, 8'h05, 1'b0, 1'b0, 0, 1'b1, 8'h41, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 1'b1, 8'h00, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b1, 8'h80, 1'b0, 1'b1);
    op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op(8'h05, 8'h07, 1'b1, 1'b1, 2, 1'b1, 8'hFD, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op(8'hAA, 8'h55, 1'b1, 1'b0, 5, 1'b1, 8'h00, 1'b1, 1'b0);

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    repeat (N + 2) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    op(8'h10, 8'h20, 1'b0, 1'b0, 0, 1'b1, 8'h30, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
         int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: operand and sum width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 2: bits added per cycle; WIDTH SHALL be a multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 The module SHALL have ports, in order:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when sub=1).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result held on outputs.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1 (for subtract, 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 An input transfer occurs on a rising edge with IDLE & in_valid; a, b, cin and sub SHALL be registered and the state SHALL become RUN with chunk index 0.
REQ-007 The effective operands SHALL be: B' = sub ? ~b : b; C0 = sub ? ~cin : cin, giving a + b + cin (add) or a - b - cin (subtract).
REQ-008 Each RUN cycle SHALL add chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) of A and B' plus the stored carry, using a CHUNK-bit ripple of full adders.
REQ-009 On each RUN cycle, the chunk sum SHALL be written to the sum register and the chunk carry-out stored for the next chunk.
REQ-010 When idx = N-1, the state SHALL become DONE; otherwise idx SHALL increment.
REQ-011 Latency: out_valid SHALL rise exactly N cycles after the input-transfer edge (4 cycles for the defaults).
REQ-012 cout SHALL be the carry out of bit WIDTH-1.
REQ-013 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-014 sum, cout and ovf SHALL be valid and stable whenever out_valid = 1.
REQ-015 DONE SHALL be held indefinitely while out_ready = 0.
REQ-016 On an edge with DONE & out_ready, the state SHALL return to IDLE.
REQ-017 Throughput: at most one operation per N+2 cycles; no new operands are accepted in RUN or DONE.
REQ-018 Input changes while not in IDLE SHALL have no effect on the result in flight.
REQ-019 sum, cout and ovf SHALL hold their last values in IDLE until the next result overwrites them.
REQ-020 CHUNK = WIDTH SHALL be legal: N = 1, latency 1 cycle.
REQ-021 CHUNK = 1 SHALL be legal: bit-serial operation, latency WIDTH cycles.

Reset
REQ-022 When rst = 1 at a rising edge, state SHALL become IDLE and idx SHALL become 0.
REQ-023 On that same edge, sum, cout and ovf SHALL become 0, so that after the edge in_ready = 1 and out_valid = 0.
REQ-024 rst SHALL override all other inputs, including an in-flight RUN or a DONE awaiting out_ready; the partial result SHALL be discarded and no out_valid SHALL follow it.

Verification
REQ-025 Scenario, add (WIDTH=8, CHUNK=2): a=8'h3C, b=8'h05, cin=0, sub=0 -> after 4 cycles out_valid=1 with sum=8'h41, cout=0, ovf=0.
REQ-026 Scenario, carry wrap: a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0.
REQ-027 Scenario, signed overflow: a=8'h7F, b=8'h01, cin=0, sub=0 -> sum=8'h80, cout=0, ovf=1.
REQ-028 Scenario, subtract with borrow: a=8'h05, b=8'h07, cin=0, sub=1 -> sum=8'hFE, cout=0, ovf=0.
- With cin=1 instead, sum SHALL be 8'hFD.
REQ-029 Scenario, backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, sum, cout and ovf stable and in_ready=0 throughout.
- out_ready=1 -> IDLE on the next edge with in_ready=1.
REQ-030 Scenario, reset mid-operation: assert rst at the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0.
- A subsequent 8'h10+8'h20 SHALL give sum=8'h30.
